// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch predictor slice.
//   satCnt_t        : 2-bit saturating direction counter
//   CNT_*           : counter encodings (strongly/weakly not-taken/taken)
//   MODE_*          : predictor selection values for the MODE parameter
//   bpEntryState_t  : per-entry control state (valid + counter); tag and
//                     target widths depend on DATA_WIDTH/ENTRIES, so those
//                     fields live beside this struct in the top module
//   isPow2()        : elaboration helper for the table-depth check
// ---------------------------------------------------------------------------
package bp_pkg;

   typedef logic [1:0] satCnt_t;

   localparam satCnt_t CNT_SNT = 2'd0;
   localparam satCnt_t CNT_WNT = 2'd1;
   localparam satCnt_t CNT_WT  = 2'd2;
   localparam satCnt_t CNT_ST  = 2'd3;

   localparam int MODE_STATIC  = 0;   // always predict not-taken
   localparam int MODE_DYNAMIC = 1;   // tagged table of 2-bit counters

   typedef struct packed {
      logic    valid;
      satCnt_t cnt;
   } bpEntryState_t;

   function automatic bit isPow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/bp_satcounter.sv
// ---------------------------------------------------------------------------
// bp_satcounter
// Next-state logic of a 2-bit saturating direction counter.
//   cntCur  : current counter value
//   taken   : resolved branch outcome
//   cntNext : counter value after training on that outcome
// Counts up on taken, down on not-taken, and sticks at CNT_ST / CNT_SNT.
// ---------------------------------------------------------------------------
module bp_satcounter
   import bp_pkg::*;
(
   input  satCnt_t cntCur,
   input  logic    taken,
   output satCnt_t cntNext
);

   always_comb begin
      cntNext = cntCur;
      if (taken) begin
         if (cntCur != CNT_ST) begin
            cntNext = cntCur + 2'd1;
         end
      end else begin
         if (cntCur != CNT_SNT) begin
            cntNext = cntCur - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-stage branch predictor with Execute-stage resolution.
//   clk, rst           : clock, synchronous active-high reset
//   pcF                : fetch PC looked up combinationally
//   predtakenF         : prediction for pcF (taken)
//   predtargetF        : predicted next PC for pcF
//   updateE            : a branch/jump resolves this cycle (already flush-gated)
//   pcE, takenE,
//   targetE            : resolving instruction PC, outcome and actual target
//   predtakenE,
//   predtargetE        : the Fetch prediction carried down with it
//   mispredictE        : redirect request for the hazard unit
//   redirectpcE        : correct next PC when mispredictE is high
//   mispredcount       : saturating count of mispredicted cycles
// MODE selects a static not-taken predictor (0) or a direct-mapped tagged
// table of 2-bit counters (1). Table entries are only allocated by taken
// branches; not-taken misses leave the table untouched.
// ---------------------------------------------------------------------------
module branch_predictor
   import bp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int MODE       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pcF,
   output logic                  predtakenF,
   output logic [DATA_WIDTH-1:0] predtargetF,
   input  logic                  updateE,
   input  logic [DATA_WIDTH-1:0] pcE,
   input  logic                  takenE,
   input  logic [DATA_WIDTH-1:0] targetE,
   input  logic                  predtakenE,
   input  logic [DATA_WIDTH-1:0] predtargetE,
   output logic                  mispredictE,
   output logic [DATA_WIDTH-1:0] redirectpcE,
   output logic [31:0]           mispredcount
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX - 2;

   // Elaboration-time parameter checks
   if (!isPow2(ENTRIES)) begin : gBadEntries
      $error("branch_predictor: ENTRIES must be a power of two and at least 2");
   end
   if ((MODE != MODE_STATIC) && (MODE != MODE_DYNAMIC)) begin : gBadMode
      $error("branch_predictor: MODE must be 0 (static) or 1 (dynamic)");
   end
   if (TAG_W < 1) begin : gBadWidth
      $error("branch_predictor: DATA_WIDTH too small for the chosen ENTRIES");
   end

   logic [DATA_WIDTH-1:0] pcFPlus4;
   logic [DATA_WIDTH-1:0] pcEPlus4;

   // Sequential fall-through; the adders wrap naturally at 2^DATA_WIDTH.
   assign pcFPlus4 = pcF + DATA_WIDTH'(4);
   assign pcEPlus4 = pcE + DATA_WIDTH'(4);

   // ------------------------------------------------------------------
   // Resolution path (identical in both modes)
   // ------------------------------------------------------------------
   // A correct not-taken prediction needs no target compare; a taken
   // outcome must match both direction and target.
   assign mispredictE = updateE &&
                        ((predtakenE != takenE) ||
                         (takenE && (predtargetE != targetE)));

   assign redirectpcE = takenE ? targetE : pcEPlus4;

   always_ff @(posedge clk) begin
      if (rst) begin
         mispredcount <= '0;
      end else if (mispredictE && (mispredcount != 32'hFFFF_FFFF)) begin
         mispredcount <= mispredcount + 32'd1;
      end
   end

   // ------------------------------------------------------------------
   // Prediction path
   // ------------------------------------------------------------------
   if (MODE == MODE_DYNAMIC) begin : gDynamic

      logic [IDX-1:0]        idxF;
      logic [IDX-1:0]        idxE;
      logic [TAG_W-1:0]      tagF;
      logic [TAG_W-1:0]      tagE;

      // Flattened read views of the per-entry registers below
      logic [ENTRIES-1:0]    validVec;
      satCnt_t               cntArr    [ENTRIES];
      logic [TAG_W-1:0]      tagArr    [ENTRIES];
      logic [DATA_WIDTH-1:0] targetArr [ENTRIES];

      logic                  hitF;
      logic                  hitE;
      logic                  tableWr;
      satCnt_t               cntE;
      satCnt_t               cntENext;

      assign idxF = pcF[IDX+1:2];
      assign tagF = pcF[DATA_WIDTH-1:IDX+2];
      assign idxE = pcE[IDX+1:2];
      assign tagE = pcE[DATA_WIDTH-1:IDX+2];

      // Zero-latency lookup; reads the registered state, so a write in
      // this same cycle is only seen from the next cycle on.
      assign hitF        = validVec[idxF] && (tagArr[idxF] == tagF);
      assign predtakenF  = hitF && cntArr[idxF][1];
      assign predtargetF = predtakenF ? targetArr[idxF] : pcFPlus4;

      assign hitE = validVec[idxE] && (tagArr[idxE] == tagE);
      assign cntE = cntArr[idxE];

      bp_satcounter uSatCounter (
         .cntCur  (cntE),
         .taken   (takenE),
         .cntNext (cntENext)
      );

      // Hits always train; misses only allocate when the branch was taken.
      assign tableWr = updateE && (hitE || takenE);

      for (genvar gi = 0; gi < ENTRIES; gi++) begin : gEntry
         bpEntryState_t         stateReg;
         logic [TAG_W-1:0]      tagReg;
         logic [DATA_WIDTH-1:0] targetReg;
         logic                  wrSel;

         assign wrSel = tableWr && (idxE == IDX'(gi));

         // Control state: reset clears valid and parks the counter at
         // weakly-not-taken; reset also wins over a coincident update.
         always_ff @(posedge clk) begin
            if (rst) begin
               stateReg.valid <= 1'b0;
               stateReg.cnt   <= CNT_WNT;
            end else if (wrSel) begin
               if (hitE) begin
                  stateReg.cnt   <= cntENext;
               end else begin
                  stateReg.valid <= 1'b1;
                  stateReg.cnt   <= CNT_WT;
               end
            end
         end

         // Payload is not reset; it is qualified by the valid bit.
         // A miss-write only happens for taken branches, so the target
         // update condition is the same for training and allocation.
         always_ff @(posedge clk) begin
            if (!rst && wrSel) begin
               if (!hitE) begin
                  tagReg <= tagE;
               end
               if (takenE) begin
                  targetReg <= targetE;
               end
            end
         end

         assign validVec[gi]  = stateReg.valid;
         assign cntArr[gi]    = stateReg.cnt;
         assign tagArr[gi]    = tagReg;
         assign targetArr[gi] = targetReg;
      end

   end else begin : gStatic

      // Static not-taken: always fall through, no table exists.
      assign predtakenF  = 1'b0;
      assign predtargetF = pcFPlus4;

   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] pcF;
   logic        updateE;
   logic [31:0] pcE;
   logic        takenE;
   logic [31:0] targetE;
   logic        predtakenE;
   logic [31:0] predtargetE;

   logic        pt1, pt0;
   logic [31:0] ptgt1, ptgt0;
   logic        misp1, misp0;
   logic [31:0] redir1, redir0;
   logic [31:0] cnt1, cnt0;

   branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .pcF(pcF),
      .predtakenF(pt1), .predtargetF(ptgt1),
      .updateE(updateE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
      .predtakenE(predtakenE), .predtargetE(predtargetE),
      .mispredictE(misp1), .redirectpcE(redir1), .mispredcount(cnt1)
   );

   branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .pcF(pcF),
      .predtakenF(pt0), .predtargetF(ptgt0),
      .updateE(updateE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
      .predtakenE(predtakenE), .predtargetE(predtargetE),
      .mispredictE(misp0), .redirectpcE(redir0), .mispredcount(cnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [31:0] pcF;
      logic        upd;
      logic [31:0] pcE;
      logic        taken;
      logic [31:0] tgt;
      logic        pT;
      logic [31:0] pTgt;
      logic        expPt;
      logic [31:0] expPtgt;
      logic        expMisp;
      logic [31:0] expRedir;
      logic [31:0] expCnt;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic [31:0] f, input logic u, input logic [31:0] e, input logic tk,
      input logic [31:0] tg, input logic p, input logic [31:0] ptg,
      input logic xPt, input logic [31:0] xPtgt, input logic xM,
      input logic [31:0] xR, input logic [31:0] xC);
      vec_t v;
      v.pcF = f; v.upd = u; v.pcE = e; v.taken = tk; v.tgt = tg;
      v.pT = p; v.pTgt = ptg; v.expPt = xPt; v.expPtgt = xPtgt;
      v.expMisp = xM; v.expRedir = xR; v.expCnt = xC;
      return v;
   endfunction

   // ---------------- reference model ----------------
   bit          mValid [16];
   int unsigned mTag   [16];
   logic [31:0] mTgt   [16];
   int          mCnt   [16];
   longint      mCount;

   function automatic void modelReset();
      for (int i = 0; i < 16; i++) begin
         mValid[i] = 1'b0;
         mCnt[i]   = 1;
      end
      mCount = 0;
   endfunction

   function automatic void modelPredict(input logic [31:0] pc, output logic pt,
                                        output logic [31:0] ptgt);
      int          i;
      int unsigned tg;
      i    = int'((pc / 4) % 16);
      tg   = pc / 64;
      pt   = mValid[i] && (mTag[i] == tg) && (mCnt[i] >= 2);
      ptgt = pt ? mTgt[i] : pc + 32'd4;
   endfunction

   function automatic logic modelMisp();
      return updateE && ((predtakenE != takenE) || (takenE && (predtargetE != targetE)));
   endfunction

   function automatic void modelClock();
      int          i;
      int unsigned tg;
      if (rst) begin
         modelReset();
         return;
      end
      if (modelMisp() && mCount < 64'hFFFF_FFFF) mCount++;
      if (updateE) begin
         i  = int'((pcE / 4) % 16);
         tg = pcE / 64;
         if (mValid[i] && mTag[i] == tg) begin
            mCnt[i] = takenE ? ((mCnt[i] + 1 > 3) ? 3 : mCnt[i] + 1)
                             : ((mCnt[i] - 1 < 0) ? 0 : mCnt[i] - 1);
            if (takenE) mTgt[i] = targetE;
         end else if (takenE) begin
            mValid[i] = 1'b1;
            mTag[i]   = tg;
            mTgt[i]   = targetE;
            mCnt[i]   = 2;
         end
      end
   endfunction

   function automatic logic [31:0] randPc();
      logic [31:0] p;
      if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
      p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      return p;
   endfunction

   initial begin
      logic        ePt;
      logic [31:0] ePtgt;
      logic        eMisp;
      logic        mPt;
      logic [31:0] mPtgt;

      //                  pcF         upd pcE         tk tgt         pT pTgt        xPt xPtgt       xM xRedir      xCnt
      vecs[0]  = mk(32'h40,       0, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h44,  0);
      vecs[1]  = mk(32'h40,       1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 0);
      vecs[2]  = mk(32'h40,       0, 32'h40, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h44,  1);
      vecs[3]  = mk(32'h40,       1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  1);
      vecs[4]  = mk(32'h40,       1, 32'h40, 0, 32'h0,   0, 32'h44,  0, 32'h44,  0, 32'h44,  2);
      vecs[5]  = mk(32'h40,       1, 32'h40, 0, 32'h0,   0, 32'h44,  0, 32'h44,  0, 32'h44,  2);
      vecs[6]  = mk(32'h40,       0, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h44,  2);
      vecs[7]  = mk(32'h0,        1, 32'h0,  1, 32'h300, 0, 32'h4,   0, 32'h4,   1, 32'h300, 2);
      vecs[8]  = mk(32'h0,        0, 32'h40, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h44,  3);
      vecs[9]  = mk(32'h40,       0, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h44,  3);
      vecs[10] = mk(32'h0,        1, 32'h0,  1, 32'h200, 1, 32'h300, 1, 32'h300, 1, 32'h200, 3);
      vecs[11] = mk(32'h0,        0, 32'h40, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h44,  4);
      vecs[12] = mk(32'hFFFFFFFC, 0, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h44,  4);
      vecs[13] = mk(32'h0,        1, 32'h0,  1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200, 4);
      vecs[14] = mk(32'h0,        0, 32'h40, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h44,  4);
      vecs[15] = mk(32'h0,        1, 32'h0,  0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h4,   4);
      vecs[16] = mk(32'h0,        0, 32'h40, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h44,  5);

      // Reset with an idle bus
      rst = 1'b1; pcF = 32'h40; updateE = 1'b0; pcE = 32'h40; takenE = 1'b0;
      targetE = 32'h0; predtakenE = 1'b0; predtargetE = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < NVEC; k++) begin
         pcF = vecs[k].pcF; updateE = vecs[k].upd; pcE = vecs[k].pcE;
         takenE = vecs[k].taken; targetE = vecs[k].tgt;
         predtakenE = vecs[k].pT; predtargetE = vecs[k].pTgt;
         #1;
         check($sformatf("vec%0d predtakenF", k),   32'(pt1),   32'(vecs[k].expPt));
         check($sformatf("vec%0d predtargetF", k),  ptgt1,      vecs[k].expPtgt);
         check($sformatf("vec%0d mispredictE", k),  32'(misp1), 32'(vecs[k].expMisp));
         check($sformatf("vec%0d redirectpcE", k),  redir1,     vecs[k].expRedir);
         check($sformatf("vec%0d mispredcount", k), cnt1,       vecs[k].expCnt);
         check($sformatf("vec%0d static predtakenF", k),   32'(pt0),   32'd0);
         check($sformatf("vec%0d static predtargetF", k),  ptgt0,      vecs[k].pcF + 32'd4);
         check($sformatf("vec%0d static mispredictE", k),  32'(misp0), 32'(vecs[k].expMisp));
         check($sformatf("vec%0d static mispredcount", k), cnt0,       vecs[k].expCnt);
         $display("vec %0d: pcF=%h upd=%0d pcE=%h tk=%0d tgt=%h -> pt=%0d ptgt=%h misp=%0d redir=%h cnt=%0d",
                  k, pcF, updateE, pcE, takenE, targetE, pt1, ptgt1, misp1, redir1, cnt1);
         @(posedge clk);
         #1;
      end

      // Reset coincident with a taken update: update is dropped, but the
      // combinational mispredict still reflects its inputs.
      rst = 1'b1; updateE = 1'b1; pcE = 32'h80; takenE = 1'b1; targetE = 32'h500;
      predtakenE = 1'b0; predtargetE = 32'h84; pcF = 32'h80;
      #1;
      check("rst+upd mispredictE", 32'(misp1), 32'd1);
      check("rst+upd redirectpcE", redir1, 32'h500);
      $display("rst+upd: pcE=%h tk=%0d misp=%0d redir=%h", pcE, takenE, misp1, redir1);
      @(posedge clk);
      #1;
      rst = 1'b0; updateE = 1'b0; pcF = 32'h80;
      #1;
      check("post-rst predtakenF 0x80", 32'(pt1), 32'd0);
      check("post-rst predtargetF 0x80", ptgt1, 32'h84);
      check("post-rst mispredcount", cnt1, 32'd0);
      check("post-rst static mispredcount", cnt0, 32'd0);
      pcF = 32'h0;
      #1;
      check("post-rst predtakenF 0x00", 32'(pt1), 32'd0);
      $display("post-rst: pt(0x80)/pt(0x0) checked, cnt=%0d", cnt1);
      @(posedge clk);
      #1;

      // ---------------- randomized phase ----------------
      modelReset();
      for (int t = 0; t < 400; t++) begin
         rst     = ($urandom_range(0, 49) == 0);
         updateE = ($urandom_range(0, 2) != 0);
         pcE     = randPc() | 32'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
         takenE  = $urandom_range(0, 1) == 1;
         targetE = 32'($urandom_range(0, 255)) << 2;
         modelPredict(pcE, mPt, mPtgt);
         if ($urandom_range(0, 3) != 0) begin
            predtakenE = mPt; predtargetE = mPtgt;
         end else begin
            predtakenE = $urandom_range(0, 1) == 1;
            predtargetE = 32'($urandom_range(0, 255)) << 2;
         end
         pcF = ($urandom_range(0, 1) == 1) ? pcE : randPc();
         #1;
         modelPredict(pcF, ePt, ePtgt);
         eMisp = modelMisp();
         check($sformatf("rnd%0d predtakenF", t),  32'(pt1),   32'(ePt));
         check($sformatf("rnd%0d predtargetF", t), ptgt1,      ePtgt);
         check($sformatf("rnd%0d mispredictE", t), 32'(misp1), 32'(eMisp));
         check($sformatf("rnd%0d redirectpcE", t), redir1,     takenE ? targetE : pcE + 32'd4);
         check($sformatf("rnd%0d mispredcount", t), cnt1,      32'(mCount));
         check($sformatf("rnd%0d static predtakenF", t),  32'(pt0), 32'd0);
         check($sformatf("rnd%0d static predtargetF", t), ptgt0,    pcF + 32'd4);
         check($sformatf("rnd%0d static mispredcount", t), cnt0,    32'(mCount));
         $display("rnd %0d: rst=%0d upd=%0d pcE=%h tk=%0d tgt=%h pcF=%h -> pt=%0d ptgt=%h misp=%0d cnt=%0d",
                  t, rst, updateE, pcE, takenE, targetE, pcF, pt1, ptgt1, misp1, cnt1);
         @(posedge clk);
         modelClock();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of every address and target.
REQ-002 Parameter ENTRIES, default 16, SHALL set the table depth; it must be a power of two and at least 2, and elaboration SHALL fail otherwise.
REQ-003 Parameter MODE, default 1, SHALL select the predictor: 0 = static not-taken, 1 = dynamic 2-bit.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 pcF  input  DATA_WIDTH  fetch-stage PC to look up.
REQ-007 predtakenF  output  1  prediction for pcF: branch taken.
REQ-008 predtargetF  output  DATA_WIDTH  predicted next PC for pcF.
REQ-009 updateE  input  1  a branch or jump resolves in Execute this cycle; the caller gates this with flushE.
REQ-010 pcE  input  DATA_WIDTH  PC of the resolving instruction.
REQ-011 takenE  input  1  actual outcome: taken.
REQ-012 targetE  input  DATA_WIDTH  actual target (pctargetE).
REQ-013 predtakenE, predtargetE  input  1, DATA_WIDTH  the prediction made in Fetch, piped down with the instruction.
REQ-014 mispredictE  output  1  redirect request to the hazard unit (flushD/flushE).
REQ-015 redirectpcE  output  DATA_WIDTH  the correct next PC when mispredictE=1.
REQ-016 mispredcount  output  32  saturating count of mispredictions.

Function
REQ-017 Index SHALL be pcF[IDX+1:2] with IDX=log2(ENTRIES); tag SHALL be pcF[DATA_WIDTH-1:IDX+2].
REQ-018 Each entry SHALL hold: a valid bit, the tag, a DATA_WIDTH-bit target, and a 2-bit counter.
REQ-019 Lookup SHALL be combinational with zero latency, so the prediction is valid in the same cycle as pcF.
REQ-020 In MODE=1, the table hits when valid=1 and the tag matches; predtakenF SHALL equal hit AND counter[1].
REQ-021 predtargetF SHALL be the stored target when predtakenF=1, and pcF+4 otherwise (wrap modulo 2^DATA_WIDTH).
REQ-022 In MODE=0, predtakenF SHALL be 0 and predtargetF SHALL be pcF+4 at all times, with no table writes.
REQ-023 mispredictE SHALL be updateE AND (predtakenE != takenE OR (takenE AND predtargetE != targetE)); it is combinational.
REQ-024 redirectpcE SHALL be targetE when takenE=1, and pcE+4 otherwise.
REQ-025 On updateE with a hit at pcE, the counter SHALL do a saturating increment if taken or a saturating decrement if not taken; it stays at 3 and at 0.
REQ-026 On that same hit, the target SHALL be overwritten with targetE when taken.
REQ-027 On updateE with a miss and takenE=1, the entry SHALL be allocated: valid=1, new tag, target=targetE, counter=2'b10. Any aliased entry is replaced.
REQ-028 On updateE with a miss and takenE=0, the table SHALL NOT change.
REQ-029 Writes SHALL be visible from the next cycle; a same-cycle lookup of the index being written returns the old contents.
REQ-030 mispredcount SHALL increment by 1 on each cycle with mispredictE=1 and hold at 0xFFFFFFFF.
REQ-031 A table write SHALL occur in both modes' update logic only when MODE=1; mispredcount SHALL count in both modes.

Reset
REQ-032 While rst=1 at a clock edge, all valid bits SHALL clear, all counters SHALL become 2'b01, and mispredcount SHALL become 0; targets and tags need not be reset.
REQ-033 After reset, predtakenF=0 and predtargetF=pcF+4; mispredictE depends only on its inputs.
REQ-034 rst SHALL take priority over a coincident updateE; the update is discarded.

Structure
REQ-035 Package bp_pkg SHALL hold: the counter typedef, the entry struct, constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3, and the MODE encodings.
REQ-036 Sub-module bp_satcounter SHALL implement the 2-bit saturating next-state logic, instantiated once on the update path.

Verification
REQ-037 Reset with pcF=0x40 -> predtakenF=0, predtargetF=0x44, mispredcount=0.
REQ-038 Update pcE=0x40, takenE=1, targetE=0x100, predtakenE=0 -> mispredictE=1, redirectpcE=0x100. Next cycle, pcF=0x40 gives predtakenF=1, predtargetF=0x100, and mispredcount=1.
REQ-039 Three not-taken updates at 0x40 after REQ-038 -> counter goes 2->1->0->0, predtakenF=0 after the first, and redirectpcE=0x44 each time.
REQ-040 ENTRIES=16: allocate 0x40 (taken), then a taken update at 0x00 (same index, different tag) -> pcF=0x40 misses (predtakenF=0) and pcF=0x00 predicts taken.
REQ-041 Predicted taken with predtargetE=0x100 but targetE=0x200 -> mispredictE=1, redirectpcE=0x200, and the stored target becomes 0x200.
REQ-042 MODE=0 with the REQ-038 stimulus -> predtakenF stays 0 and mispredictE=1; a coincident rst=1 with updateE leaves the table empty.
